// File: rtl/conv_engine_pkg.sv
// Shared types, defaults and sizing helpers for the convolution engine.
package conv_engine_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  localparam int DEF_N  = 6;
  localparam int DEF_K  = 2;
  localparam int DEF_PW = 3;
  localparam int DEF_NK = 6;

  // Result width: full product plus growth from summing K*K terms.
  function automatic int calc_ow(input int pw, input int k);
    return 2 * pw + $clog2(k * k);
  endfunction

  // Output rows/columns per kernel for stride s.
  function automatic int calc_m(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_engine_if.sv
// Load/result bus of the convolution engine.
interface conv_engine_if
  import conv_engine_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int K  = DEF_K,
  parameter int PW = DEF_PW,
  parameter int NK = DEF_NK
) ();

  localparam int OW = calc_ow(PW, K);

  logic                in_valid;
  logic [N*PW-1:0]     in_row;
  logic [K*K*PW-1:0]   in_kernel;
  logic                in_stride;
  logic                out_ready;
  logic                out_valid;
  logic [OW-1:0]       out_data;

  modport master (
    output in_valid, in_row, in_kernel, in_stride, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_row, in_kernel, in_stride, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/conv_engine_mac.sv
// K x K dot product of unsigned operands, registered once (the CALC stage).
module conv_mac
  import conv_engine_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int PW = DEF_PW,
  parameter int OW = calc_ow(DEF_PW, DEF_K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [K*K*PW-1:0] window,
  input  logic [K*K*PW-1:0] kernel,
  output logic [OW-1:0]     result
);

  logic [OW-1:0] prod [K*K];
  logic [OW-1:0] acc;

  // Operands are widened before multiplying so products are exact.
  for (genvar gi = 0; gi < K * K; gi++) begin : g_prod
    assign prod[gi] = OW'(window[gi*PW +: PW]) * OW'(kernel[gi*PW +: PW]);
  end

  // Sum all products; wraps modulo 2^OW, which cannot occur at OW = 2*PW+clog2(K*K).
  always_comb begin
    acc = '0;
    for (int e = 0; e < K * K; e++) begin
      acc = acc + prod[e];
    end
  end

  // Pipeline register holding the dot product of the selected window.
  always_ff @(posedge clk) begin
    if (!rst_n) result <= '0;
    else        result <= acc;
  end

endmodule

// File: rtl/conv_engine.sv
// Convolution engine: loads an N x N matrix and NK kernels, then streams
// NK*M*M results kernel-major with a valid/ready handshake.
module conv_engine
  import conv_engine_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int K  = DEF_K,
  parameter int PW = DEF_PW,
  parameter int NK = DEF_NK
) (
  input  logic         clk,
  input  logic         rst_n,
  conv_engine_if.slave bus
);

  localparam int OW  = calc_ow(PW, K);
  localparam int L   = (N > NK) ? N : NK;
  localparam int IW  = cw(N);
  localparam int KW  = cw(NK);
  localparam int LW  = cw(L);
  localparam int ML1 = calc_m(N, K, 1) - 1;
  localparam int ML2 = calc_m(N, K, 2) - 1;

  state_t            state_reg, state_next;
  logic [LW-1:0]     load_cnt_reg;
  logic              stride_reg;
  logic [KW-1:0]     cnt_k_reg, nxt_k, sel_k;
  logic [IW-1:0]     cnt_i_reg, nxt_i, sel_i;
  logic [IW-1:0]     cnt_j_reg, nxt_j, sel_j;
  logic [IW-1:0]     m_last, row_base, col_base;
  logic [PW-1:0]     mat [N][N];
  logic [K*K*PW-1:0] ker [NK];
  logic [K*K*PW-1:0] win;
  logic [OW-1:0]     mac_res;
  logic [LW-1:0]     cyc;
  logic              accept, last_load, fire, last_pos;

  assign accept    = bus.in_valid && (state_reg == IDLE || state_reg == LOAD);
  assign cyc       = (state_reg == LOAD) ? load_cnt_reg : '0;
  assign last_load = (cyc == LW'(L - 1));
  assign fire      = (state_reg == OUT) && bus.out_ready;
  assign m_last    = stride_reg ? IW'(ML2) : IW'(ML1);
  assign last_pos  = (cnt_k_reg == KW'(NK - 1)) && (cnt_i_reg == m_last) && (cnt_j_reg == m_last);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; a gap in in_valid during LOAD aborts the load.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = last_load ? CALC : LOAD;
      LOAD: if (!bus.in_valid) state_next = IDLE;
            else if (last_load) state_next = CALC;
      CALC: state_next = OUT;
      OUT:  if (fire && last_pos) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: valid only in OUT, data forced to zero otherwise.
  always_comb begin
    bus.out_valid = (state_reg == OUT);
    bus.out_data  = (state_reg == OUT) ? mac_res : '0;
  end

  // Load-cycle counter and stride capture on the first input cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt_reg <= '0;
      stride_reg   <= 1'b0;
    end else begin
      load_cnt_reg <= accept ? cyc + LW'(1) : '0;
      if (state_reg == IDLE && bus.in_valid) stride_reg <= bus.in_stride;
    end
  end

  // Successor of the current result position (column, then row, then kernel).
  always_comb begin
    nxt_k = cnt_k_reg;
    nxt_i = cnt_i_reg;
    nxt_j = cnt_j_reg + IW'(1);
    if (cnt_j_reg == m_last) begin
      nxt_j = '0;
      if (cnt_i_reg == m_last) begin
        nxt_i = '0;
        nxt_k = cnt_k_reg + KW'(1);
      end else begin
        nxt_i = cnt_i_reg + IW'(1);
      end
    end
  end

  // Result position counters; parked at zero outside OUT so CALC computes result 0.
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != OUT) begin
      cnt_k_reg <= '0;
      cnt_i_reg <= '0;
      cnt_j_reg <= '0;
    end else if (fire) begin
      cnt_k_reg <= nxt_k;
      cnt_i_reg <= nxt_i;
      cnt_j_reg <= nxt_j;
    end
  end

  // The MAC looks one position ahead on a transfer, so results stream back to back.
  assign sel_k = fire ? nxt_k : cnt_k_reg;
  assign sel_i = fire ? nxt_i : cnt_i_reg;
  assign sel_j = fire ? nxt_j : cnt_j_reg;
  assign row_base = sel_i << stride_reg;
  assign col_base = sel_j << stride_reg;

  for (genvar gi = 0; gi < N; gi++) begin : g_rows
    // Matrix row gi is captured on input cycle gi.
    always_ff @(posedge clk) begin
      if (accept && cyc == LW'(gi)) begin
        for (int c = 0; c < N; c++) mat[gi][c] <= bus.in_row[c*PW +: PW];
      end
    end
  end

  for (genvar gi = 0; gi < NK; gi++) begin : g_kernels
    // Kernel gi is captured on input cycle gi.
    always_ff @(posedge clk) begin
      if (accept && cyc == LW'(gi)) ker[gi] <= bus.in_kernel;
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_win_r
    for (genvar gj = 0; gj < K; gj++) begin : g_win_c
      assign win[(gi*K+gj)*PW +: PW] = mat[row_base + IW'(gi)][col_base + IW'(gj)];
    end
  end

  conv_mac #(.K(K), .PW(PW), .OW(OW)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .window (win),
    .kernel (ker[sel_k]),
    .result (mac_res)
  );

endmodule

// File: tb/tb_conv_engine.sv
// Directed/random bench for conv_engine: default build plus an N=8,K=3,PW=4,NK=2 build.
module tb_conv_engine;
  import conv_engine_pkg::*;

  localparam int AN = 6, AK = 2, APW = 3, ANK = 6, AOW = calc_ow(APW, AK), AL = 6;
  localparam int BN = 8, BK = 3, BPW = 4, BNK = 2, BOW = calc_ow(BPW, BK), BL = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_engine_if #(.N(AN), .K(AK), .PW(APW), .NK(ANK)) bus_a ();
  conv_engine_if #(.N(BN), .K(BK), .PW(BPW), .NK(BNK)) bus_b ();

  conv_engine #(.N(AN), .K(AK), .PW(APW), .NK(ANK)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  conv_engine #(.N(BN), .K(BK), .PW(BPW), .NK(BNK)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int compared   = 0;
  int mismatched = 0;
  int mx [8][8];
  int kx [6][9];
  int exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Matrix and kernels: constant v, or random in [0,maxv] when v < 0.
  task automatic fill(input int n, input int k, input int nk, input int v, input int maxv);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) mx[r][c] = (v >= 0) ? v : int'($urandom_range(0, maxv));
    for (int q = 0; q < nk; q++)
      for (int e = 0; e < k * k; e++) kx[q][e] = (v >= 0) ? v : int'($urandom_range(0, maxv));
  endtask

  // Reference: direct definition of a strided convolution, kernel-major order.
  function automatic void build_exp(input int n, input int k, input int nk, input int ow, input int s);
    int m, sum;
    m = (n - k) / s + 1;
    exp_q.delete();
    for (int q = 0; q < nk; q++)
      for (int i = 0; i < m; i++)
        for (int j = 0; j < m; j++) begin
          sum = 0;
          for (int a = 0; a < k; a++)
            for (int b = 0; b < k; b++)
              sum += mx[i*s+a][j*s+b] * kx[q][a*k+b];
          exp_q.push_back(sum & ((1 << ow) - 1));
        end
  endfunction

  // Drive nvalid input cycles; stride is meaningful only on the first one.
  task automatic send_a(input int stride, input int nvalid);
    for (int c = 0; c < nvalid; c++) begin
      bus_a.in_valid = 1'b1;
      for (int col = 0; col < AN; col++) bus_a.in_row[col*APW +: APW] = APW'(mx[c][col]);
      for (int e = 0; e < AK * AK; e++) bus_a.in_kernel[e*APW +: APW] = APW'(kx[c][e]);
      bus_a.in_stride = (c == 0) ? stride[0] : 1'($urandom);
      @(posedge clk); #1;
    end
    bus_a.in_valid = 1'b0;
  endtask

  // Consume results, optionally stalling at one index or pulsing reset at one index.
  task automatic collect_a(input int total, input int stall_at, input int stall_len, input int rst_at);
    int idx = 0, stall = 0, cyc = 0;
    check("latency_calc_valid", bus_a.out_valid, 0);
    @(posedge clk); #1;
    while (idx < total && cyc < total + stall_len + 20) begin
      if (idx == rst_at) begin
        bus_a.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_valid", bus_a.out_valid, 0);
        check("rst_mid_data", bus_a.out_data, 0);
        repeat (5) begin
          @(posedge clk); #1;
          check("rst_no_partial", bus_a.out_valid, 0);
        end
        return;
      end
      bus_a.out_ready = !(idx == stall_at && stall < stall_len);
      if (idx == stall_at && stall < stall_len) stall++;
      bus_a.in_valid = (idx < total - 1) ? 1'($urandom) : 1'b0;
      bus_a.in_row   = AN*APW'($urandom);
      check($sformatf("valid[%0d]", idx), bus_a.out_valid, 1);
      check($sformatf("data[%0d]", idx), bus_a.out_data, exp_q[idx]);
      if (bus_a.out_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    check("result_count", idx, total);
    check("valid_after_last", bus_a.out_valid, 0);
    check("data_after_last", bus_a.out_data, 0);
  endtask

  initial begin
    int idx, cyc;
    bus_a.in_valid = 1'b0; bus_a.in_row = '0; bus_a.in_kernel = '0; bus_a.in_stride = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_row = '0; bus_b.in_kernel = '0; bus_b.in_stride = 1'b0; bus_b.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_a_valid", bus_a.out_valid, 0);
    check("reset_a_data", bus_a.out_data, 0);
    check("reset_b_valid", bus_b.out_valid, 0);
    check("reset_b_data", bus_b.out_data, 0);

    // All ones, stride 1: 150 results of 4.
    fill(AN, AK, ANK, 1, 0);
    build_exp(AN, AK, ANK, AOW, 1);
    send_a(0, AL);
    collect_a(150, -1, 0, -1);

    // All sevens, stride 2: 54 results of 196.
    fill(AN, AK, ANK, 7, 0);
    build_exp(AN, AK, ANK, AOW, 2);
    send_a(1, AL);
    collect_a(54, -1, 0, -1);

    // Random data with a 3-cycle stall at result 10.
    fill(AN, AK, ANK, -1, 7);
    build_exp(AN, AK, ANK, AOW, 1);
    send_a(0, AL);
    collect_a(150, 10, 3, -1);

    // Aborted load, then a full random stride-2 transaction.
    fill(AN, AK, ANK, -1, 7);
    send_a(0, 3);
    repeat (8) begin
      check("abort_no_valid", bus_a.out_valid, 0);
      @(posedge clk); #1;
    end
    fill(AN, AK, ANK, -1, 7);
    build_exp(AN, AK, ANK, AOW, 2);
    send_a(1, AL);
    collect_a(54, -1, 0, -1);

    // Reset at result 40, then a fresh transaction.
    fill(AN, AK, ANK, -1, 7);
    build_exp(AN, AK, ANK, AOW, 1);
    send_a(0, AL);
    collect_a(150, -1, 0, 40);
    fill(AN, AK, ANK, -1, 7);
    build_exp(AN, AK, ANK, AOW, 1);
    send_a(0, AL);
    collect_a(150, 5, 1, -1);

    // Second build: N=8, K=3, PW=4, NK=2, all fifteens -> 72 results of 2025.
    fill(BN, BK, BNK, 15, 0);
    build_exp(BN, BK, BNK, BOW, 1);
    for (int c = 0; c < BL; c++) begin
      bus_b.in_valid = 1'b1;
      for (int col = 0; col < BN; col++) bus_b.in_row[col*BPW +: BPW] = BPW'(mx[c][col]);
      for (int e = 0; e < BK * BK; e++)
        bus_b.in_kernel[e*BPW +: BPW] = (c < BNK) ? BPW'(kx[c][e]) : BPW'($urandom);
      bus_b.in_stride = (c == 0) ? 1'b0 : 1'($urandom);
      @(posedge clk); #1;
    end
    bus_b.in_valid = 1'b0;
    check("b_latency_calc_valid", bus_b.out_valid, 0);
    @(posedge clk); #1;
    idx = 0;
    cyc = 0;
    while (idx < 72 && cyc < 100) begin
      check($sformatf("b_valid[%0d]", idx), bus_b.out_valid, 1);
      check($sformatf("b_data[%0d]", idx), bus_b.out_data, exp_q[idx]);
      idx++;
      @(posedge clk); #1;
      cyc++;
    end
    check("b_result_count", idx, 72);
    check("b_valid_after_last", bus_b.out_valid, 0);
    check("b_data_after_last", bus_b.out_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter N, default 6: input matrix is N x N, N >= K.
REQ-002 Parameter K, default 2: kernel is K x K.
REQ-003 Parameter PW, default 3: unsigned pixel and kernel-element width.
REQ-004 Parameter NK, default 6: kernels per transaction.
REQ-005 Derived OW = 2*PW + clog2(K*K), which is 8 at the defaults, SHALL be the output width.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-008 in_valid  input  1  high for exactly L = max(N,NK) consecutive cycles per transaction.
REQ-009 in_row  input  N*PW  one matrix row; bits [PW-1:0] = column 0.
REQ-010 in_kernel  input  K*K*PW  one kernel, row-major; bits [PW-1:0] = element (0,0).
REQ-011 in_stride  input  1  0 = stride 1, 1 = stride 2; sampled on the first in_valid cycle only.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_valid  output  1  out_data holds a result.
REQ-014 out_data  output  OW  convolution result.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, CALC, OUT.
- IDLE -> LOAD on in_valid.
- LOAD -> CALC after the L-th in_valid cycle.
- CALC -> OUT after one cycle.
- OUT -> IDLE after the last result is accepted.
REQ-016 Capture in LOAD: in_row on input cycles 0..N-1 as matrix rows 0..N-1; in_kernel on cycles 0..NK-1 as kernels 0..NK-1; other lanes ignored.
REQ-017 Output dimension: M = floor((N-K)/S)+1, with S = 1 or 2; total results T = NK*M*M.
REQ-018 Result definition: out(k,i,j) = sum over a,b < K of X[i*S+a][j*S+b] * W_k[a][b], computed exactly in OW bits with no saturation.
REQ-019 Result order: kernel-major, then output row i, then column j, ascending.
REQ-020 Latency: first out_valid is high on the second rising edge after the last in_valid cycle.
REQ-021 Handshake: a result transfers when out_valid && out_ready.
- While out_valid && !out_ready, out_data and the result index SHALL hold stable.
- After a transfer, the next result appears on the next cycle, giving a sustained one result per cycle.
REQ-022 out_valid SHALL deassert in the cycle after the T-th transfer; out_data SHALL return to 0 whenever out_valid is low.
REQ-023 If in_valid drops in LOAD before L cycles, the block SHALL abort: return to IDLE with no output.
REQ-024 in_valid in CALC or OUT SHALL be ignored; a new transaction is accepted only from IDLE, earliest the cycle after the last transfer.
REQ-025 in_stride changes after the first in_valid cycle SHALL have no effect.

Reset
REQ-026 On a rising edge with rst_n low, the block SHALL set: FSM = IDLE, all counters 0, out_valid = 0, out_data = 0.
REQ-027 Reset asserted mid-LOAD or mid-OUT SHALL abort the transaction.
- Outputs are 0 from the next edge.
- No partial result appears after rst_n rises.
REQ-028 Matrix and kernel storage need not be cleared by reset.

Structure
REQ-029 Shared package conv_engine_pkg SHALL hold: the state enum, default parameter values, and the OW/M helper functions.
REQ-030 One sub-module conv_mac SHALL compute the K x K dot product of PW-bit operands into OW bits, registered once; this register is the CALC stage.
REQ-031 Storage SHALL be flip-flop arrays N*N*PW + NK*K*K*PW; no SRAM macros.

Verification
REQ-032 Defaults, all pixels and weights 1, stride 1, out_ready=1 -> 150 consecutive results, each = 4.
REQ-033 Defaults, all values 7, stride 2 -> 54 results, each = 196; out_valid low on result cycle 55.
REQ-034 Defaults, random data; out_ready low for 3 cycles at result 10 -> result 10 held stable; the full 150-result sequence matches the reference model.
REQ-035 in_valid dropped after 3 cycles -> no out_valid; a following full transaction is correct.
REQ-036 rst_n low for 1 cycle at result 40 -> out_valid=0 and out_data=0 from the next edge; the next transaction is correct.
REQ-037 N=8, K=3, PW=4, NK=2, all values 15, stride 1 -> OW=12, 72 results, each = 2025.
